// File: rtl/contador_prog_if.sv
// Control and status bundle of the programmable counter.
// The master side drives the controls and the slave side (the counter)
// returns the registered status.
interface contador_prog_if #(
  parameter int BITS     = 29,
  parameter int PRE_BITS = 8
);
  logic                Enable;
  logic                up_down;
  logic                saturate;
  logic                load;
  logic [BITS-1:0]     load_value;
  logic [BITS-1:0]     limit;
  logic [PRE_BITS-1:0] prescale;
  logic                clear_flag;
  logic [BITS-1:0]     count;
  logic                tc;
  logic                wrap_flag;

  modport master (
    output Enable, up_down, saturate, load, load_value, limit, prescale, clear_flag,
    input  count, tc, wrap_flag
  );

  modport slave (
    input  Enable, up_down, saturate, load, load_value, limit, prescale, clear_flag,
    output count, tc, wrap_flag
  );
endinterface

// File: rtl/contador_prog.sv
// Programmable counter clocked on the falling edge of NEclk.
// Features: active-low enable, prescaler, up/down, wrap or saturate,
// synchronous load, terminal-count pulse and sticky wrap flag.
module contador_prog #(
  parameter int BITS     = 29,
  parameter int PRE_BITS = 8
) (
  input logic            NEclk,
  input logic            reset,
  contador_prog_if.slave bus
);

  localparam logic [BITS-1:0]     ONE     = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [PRE_BITS-1:0] PRE_ONE = {{(PRE_BITS-1){1'b0}}, 1'b1};

  logic [BITS-1:0]     r_count;
  logic [PRE_BITS-1:0] r_pre_cnt;
  logic                r_tc;
  logic                r_wrap_flag;

  logic [BITS-1:0]     w_count_next;
  logic [PRE_BITS-1:0] w_pre_cnt_next;
  logic                w_tc_next;
  logic                w_wrap_flag_next;
  logic                w_wrap_set;
  logic                w_pre_done;
  logic                w_up_term;
  logic                w_dn_term;

  // The prescaler fires once its phase has reached the programmed divide value;
  // the >= compare keeps it well-behaved when prescale shrinks mid-count.
  assign w_pre_done = (r_pre_cnt >= bus.prescale);
  // Up-counting treats anything at or above limit as terminal (covers loads above limit).
  assign w_up_term  = (r_count >= bus.limit);
  assign w_dn_term  = (r_count == '0);

  // Next-state computation: load beats a prescaled step; reset is applied in the register.
  always_comb begin
    w_count_next   = r_count;
    w_pre_cnt_next = r_pre_cnt;
    w_tc_next      = 1'b0;
    w_wrap_set     = 1'b0;
    if (bus.load) begin
      w_count_next   = bus.load_value;
      w_pre_cnt_next = '0;
    end else if (!bus.Enable) begin
      if (w_pre_done) begin
        w_pre_cnt_next = '0;
        if (bus.up_down) begin
          if (!w_up_term) begin
            w_count_next = r_count + ONE;
          end else begin
            w_tc_next = 1'b1;
            if (bus.saturate) begin
              // Clamp a value that was loaded above limit; otherwise hold.
              w_count_next = bus.limit;
            end else begin
              w_count_next = '0;
              w_wrap_set   = 1'b1;
            end
          end
        end else begin
          if (!w_dn_term) begin
            w_count_next = r_count - ONE;
          end else begin
            w_tc_next = 1'b1;
            if (bus.saturate) begin
              w_count_next = '0;
            end else begin
              w_count_next = bus.limit;
              w_wrap_set   = 1'b1;
            end
          end
        end
      end else begin
        w_pre_cnt_next = r_pre_cnt + PRE_ONE;
      end
    end
  end

  // Sticky flag: a new wrap wins over a clear requested on the same edge.
  always_comb begin
    w_wrap_flag_next = r_wrap_flag;
    if (w_wrap_set) begin
      w_wrap_flag_next = 1'b1;
    end else if (bus.clear_flag) begin
      w_wrap_flag_next = 1'b0;
    end
  end

  // State register on the falling edge with synchronous reset.
  always_ff @(negedge NEclk) begin
    if (reset) begin
      r_count     <= '0;
      r_pre_cnt   <= '0;
      r_tc        <= 1'b0;
      r_wrap_flag <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_pre_cnt   <= w_pre_cnt_next;
      r_tc        <= w_tc_next;
      r_wrap_flag <= w_wrap_flag_next;
    end
  end

  assign bus.count     = r_count;
  assign bus.tc        = r_tc;
  assign bus.wrap_flag = r_wrap_flag;

endmodule

// File: tb/tb_contador_prog.sv
// Directed bench for contador_prog: a 29-bit instance for the main features
// and a 4-bit instance for full-width roll-over.
module tb_contador_prog;

  logic NEclk = 1'b1;
  logic rst_a;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 NEclk = ~NEclk;

  contador_prog_if #(.BITS(29), .PRE_BITS(8)) ia ();
  contador_prog_if #(.BITS(4),  .PRE_BITS(8)) ib ();

  contador_prog #(.BITS(29), .PRE_BITS(8)) u_a (
    .NEclk (NEclk),
    .reset (rst_a),
    .bus   (ia)
  );

  contador_prog #(.BITS(4), .PRE_BITS(8)) u_b (
    .NEclk (NEclk),
    .reset (rst_b),
    .bus   (ib)
  );

  task automatic tick();
    @(negedge NEclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on instance A: one edge, then count/tc/wrap_flag compared.
  task automatic step_a(input string tag, input int exp_cnt, input logic exp_tc, input logic exp_wf);
    tick();
    chk({tag, ".count"}, 32'(ia.count), 32'(exp_cnt));
    chk({tag, ".tc"}, 32'(ia.tc), 32'(exp_tc));
    chk({tag, ".wrap"}, 32'(ia.wrap_flag), 32'(exp_wf));
    $display("A %-12s count=%0d tc=%0b wrap=%0b", tag, ia.count, ia.tc, ia.wrap_flag);
  endtask

  task automatic step_b(input string tag, input int exp_cnt, input logic exp_tc, input logic exp_wf);
    tick();
    chk({tag, ".count"}, 32'(ib.count), 32'(exp_cnt));
    chk({tag, ".tc"}, 32'(ib.tc), 32'(exp_tc));
    chk({tag, ".wrap"}, 32'(ib.wrap_flag), 32'(exp_wf));
    chk({tag, ".nox"}, 32'($isunknown({ib.count, ib.tc, ib.wrap_flag})), 32'(0));
    $display("B %-12s count=%0d tc=%0b wrap=%0b", tag, ib.count, ib.tc, ib.wrap_flag);
  endtask

  initial begin
    // Reset both instances with everything idle.
    rst_a = 1'b1; rst_b = 1'b1;
    ia.Enable = 1'b1; ia.up_down = 1'b1; ia.saturate = 1'b0; ia.load = 1'b0;
    ia.load_value = '0; ia.limit = 29'd5; ia.prescale = 8'd0; ia.clear_flag = 1'b0;
    ib.Enable = 1'b1; ib.up_down = 1'b1; ib.saturate = 1'b0; ib.load = 1'b0;
    ib.load_value = '0; ib.limit = 4'd15; ib.prescale = 8'd0; ib.clear_flag = 1'b0;
    step_a("rst", 0, 1'b0, 1'b0);
    step_b("rst_b", 0, 1'b0, 1'b0);

    // Basic count, limit 5, wrap.
    rst_a = 1'b0; ia.Enable = 1'b0;
    step_a("up1", 1, 1'b0, 1'b0);
    step_a("up2", 2, 1'b0, 1'b0);
    step_a("up3", 3, 1'b0, 1'b0);
    step_a("up4", 4, 1'b0, 1'b0);
    step_a("up5", 5, 1'b0, 1'b0);
    step_a("wrap0", 0, 1'b1, 1'b1);
    step_a("after1", 1, 1'b0, 1'b1);

    // Load 0 with clear, then prescale 2 and an enable hold mid-phase.
    ia.load = 1'b1; ia.load_value = 29'd0; ia.clear_flag = 1'b1;
    step_a("ld0", 0, 1'b0, 1'b0);
    ia.load = 1'b0; ia.clear_flag = 1'b0; ia.prescale = 8'd2; ia.limit = 29'd100;
    step_a("pre_e1", 0, 1'b0, 1'b0);
    step_a("pre_e2", 0, 1'b0, 1'b0);
    step_a("pre_e3", 1, 1'b0, 1'b0);
    step_a("pre_e4", 1, 1'b0, 1'b0);
    ia.Enable = 1'b1;
    step_a("hold1", 1, 1'b0, 1'b0);
    step_a("hold2", 1, 1'b0, 1'b0);
    step_a("hold3", 1, 1'b0, 1'b0);
    step_a("hold4", 1, 1'b0, 1'b0);
    ia.Enable = 1'b0;
    step_a("resume1", 1, 1'b0, 1'b0);
    step_a("resume2", 2, 1'b0, 1'b0);

    // Saturating down count from 2, then wrap down to limit 7.
    ia.load = 1'b1; ia.load_value = 29'd2; ia.prescale = 8'd0;
    ia.saturate = 1'b1; ia.up_down = 1'b0;
    step_a("ld2", 2, 1'b0, 1'b0);
    ia.load = 1'b0;
    step_a("dn1", 1, 1'b0, 1'b0);
    step_a("dn0", 0, 1'b0, 1'b0);
    step_a("sat0a", 0, 1'b1, 1'b0);
    step_a("sat0b", 0, 1'b1, 1'b0);
    ia.saturate = 1'b0; ia.limit = 29'd7;
    step_a("dnwrap", 7, 1'b1, 1'b1);
    step_a("dn6", 6, 1'b0, 1'b1);

    // Load above limit, wrap then saturate.
    ia.load = 1'b1; ia.load_value = 29'd20; ia.limit = 29'd10;
    ia.up_down = 1'b1; ia.clear_flag = 1'b1;
    step_a("ld20", 20, 1'b0, 1'b0);
    ia.load = 1'b0; ia.clear_flag = 1'b0;
    step_a("above_wrap", 0, 1'b1, 1'b1);
    ia.load = 1'b1; ia.saturate = 1'b1;
    step_a("ld20s", 20, 1'b0, 1'b1);
    ia.load = 1'b0;
    step_a("above_sat", 10, 1'b1, 1'b1);
    step_a("sat_hold", 10, 1'b1, 1'b1);

    // Reset beats load; wrap beats clear; clear alone clears.
    rst_a = 1'b1; ia.load = 1'b1; ia.load_value = 29'd33;
    step_a("rst_ld", 0, 1'b0, 1'b0);
    rst_a = 1'b0; ia.load = 1'b0; ia.limit = 29'd1; ia.saturate = 1'b0;
    step_a("c1", 1, 1'b0, 1'b0);
    ia.clear_flag = 1'b1;
    step_a("wrap_clr", 0, 1'b1, 1'b1);
    ia.Enable = 1'b1;
    step_a("clr_only", 0, 1'b0, 1'b0);
    ia.clear_flag = 1'b0;

    // Reset mid-prescale restarts the prescale phase.
    ia.Enable = 1'b0; ia.limit = 29'd100; ia.prescale = 8'd3;
    step_a("p3_e1", 0, 1'b0, 1'b0);
    step_a("p3_e2", 0, 1'b0, 1'b0);
    rst_a = 1'b1;
    step_a("p3_rst", 0, 1'b0, 1'b0);
    rst_a = 1'b0;
    step_a("p3_r1", 0, 1'b0, 1'b0);
    step_a("p3_r2", 0, 1'b0, 1'b0);
    step_a("p3_r3", 0, 1'b0, 1'b0);
    step_a("p3_r4", 1, 1'b0, 1'b0);

    // Full width on the 4-bit instance.
    rst_b = 1'b0; ib.Enable = 1'b0; ib.up_down = 1'b0; ib.saturate = 1'b0;
    step_b("b_dnwrap", 15, 1'b1, 1'b1);
    step_b("b_14", 14, 1'b0, 1'b1);
    step_b("b_13", 13, 1'b0, 1'b1);
    ib.load = 1'b1; ib.load_value = 4'd15; ib.up_down = 1'b1;
    step_b("b_ld15", 15, 1'b0, 1'b1);
    ib.load = 1'b0;
    step_b("b_upwrap", 0, 1'b1, 1'b1);
    step_b("b_1", 1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
